mant_mul_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 16 +
 rtl/mant_mul_seq_add.sv | 28 ++
 rtl/mant_mul_seq.sv | 112 +++++++++++
 tb/tb_mant_mul_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions.
//   mul_state_t : sequential mantissa multiplier states
//   MANT_W_SP   : single-precision mantissa width, hidden bit included
//   MANT_W_DP   : double-precision mantissa width, hidden bit included
package fp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_t;

   localparam int unsigned MANT_W_SP = 24;
   localparam int unsigned MANT_W_DP = 53;

endpackage

// File: rtl/mant_mul_seq_add.sv
// Partial-product adder for the shift-and-add mantissa multiplier.
// A WIDTH-bit ripple-carry chain of full-adder cells with carry-in tied low.
// Ports:
//   a_i    : running high partial product
//   b_i    : gated multiplicand
//   s_o    : WIDTH-bit sum
//   cout_o : carry out of the top cell
module mul_step_add #(
   parameter int unsigned WIDTH = 24
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] s_o,
   output logic             cout_o
);

   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = carry[WIDTH];

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential unsigned mantissa multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One shared ripple adder performs a shift-and-add step per cycle for WIDTH cycles.
// Ports:
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   : operand handshake (in_a_i, in_b_i sampled on accept)
//   out_valid_o / out_ready_i : product handshake, out_p_o held until accepted
//   busy_o                    : high while computing or holding a result
module mant_mul_seq
   import fp_pkg::*;
#(
   parameter int unsigned WIDTH = MANT_W_SP
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     in_a_i,
   input  logic [WIDTH-1:0]     in_b_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [2*WIDTH-1:0]   out_p_o,
   output logic                 busy_o
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic             cout;

   // Multiplier LSB gates the multiplicand into the adder.
   assign addend = mplr_q[0] ? mcand_q : '0;

   mul_step_add #(
      .WIDTH (WIDTH)
   ) u_step_add (
      .a_i    (acc_q),
      .b_i    (addend),
      .s_o    (sum),
      .cout_o (cout)
   );

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               mcand_d = in_a_i;
               mplr_d  = in_b_i;
               acc_d   = '0;
               cnt_d   = '0;
               // Zero operand: the product is known, skip the WIDTH steps.
               if (in_a_i == '0 || in_b_i == '0) begin
                  mplr_d  = '0;
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // {acc, mplr} <= {cout, sum, mplr} >> 1
            acc_d  = {cout, sum[WIDTH-1:1]};
            mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode from state only; partial products never reach out_p_o.
   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign out_p_o     = (state_q == DONE) ? {acc_q, mplr_q} : '0;

endmodule

// File: tb/tb_mant_mul_seq.sv
module tb_mant_mul_seq;

   localparam int W = 24;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_a;
   logic [W-1:0]    in_b;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  out_p;
   logic            busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   mant_mul_seq #(
      .WIDTH (W)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_p_o     (out_p),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Present one operand pair from IDLE, then count clock edges after the accept
   // edge until out_valid is seen (-1 if it never comes).
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      @(negedge clk);
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = ~a;
      in_b     = ~b;
      lat      = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   // One-cycle out_ready pulse to consume a held result.
   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset: got rdy=%b vld=%b p=%h busy=%b, expected 1 0 0 0",
                  in_ready, out_valid, out_p, busy);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_unit();
      int lat;
      do_op(24'h800000, 24'h800000, lat);
      checks++;
      if (lat !== W) begin
         errors++;
         $display("FAIL unit_latency: got %0d expected %0d", lat, W);
      end
      checks++;
      if (out_p !== 48'h400000000000) begin
         errors++;
         $display("FAIL unit_product: got %h expected %h", out_p, 48'h400000000000);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL unit_done_flags: got rdy=%b busy=%b expected 0 1", in_ready, busy);
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_p !== '0) begin
         errors++;
         $display("FAIL unit_release: got rdy=%b vld=%b busy=%b p=%h expected 1 0 0 0",
                  in_ready, out_valid, busy, out_p);
      end
   endtask

   task automatic test_max();
      int lat;
      do_op(24'hFFFFFF, 24'hFFFFFF, lat);
      checks++;
      if (lat !== W || out_p !== 48'hFFFFFE000001) begin
         errors++;
         $display("FAIL max_product: got lat=%0d p=%h expected lat=%0d p=%h",
                  lat, out_p, W, 48'hFFFFFE000001);
      end
      release_out();
   endtask

   task automatic test_zero();
      int lat;
      // Zero operand goes straight to DONE on the accept edge.
      do_op(24'h000000, 24'hABCDEF, lat);
      checks++;
      if (lat !== 0 || out_p !== '0) begin
         errors++;
         $display("FAIL zero_shortcut: got lat=%0d p=%h expected lat=0 p=0", lat, out_p);
      end
      release_out();
      do_op(24'hC00000, 24'hA00000, lat);
      checks++;
      if (lat !== W || out_p !== 48'h780000000000) begin
         errors++;
         $display("FAIL zero_then_normal: got lat=%0d p=%h expected lat=%0d p=%h",
                  lat, out_p, W, 48'h780000000000);
      end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      do_op(24'h000003, 24'h000005, lat);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = (i == 3);
         in_a     = 24'h000005;
         in_b     = 24'h000007;
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || out_p !== 48'h00000000000F || in_ready !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_release: got rdy=%b vld=%b expected 1 0",
                  in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_pulse_ignored: got busy=%b rdy=%b expected 0 1",
                  busy, in_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      @(negedge clk);
      in_a     = 24'hFFFFFF;
      in_b     = 24'h7FFFFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midrun_busy: got %b expected 1", busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: got vld=%b rdy=%b p=%h busy=%b expected 0 1 0 0",
                  out_valid, in_ready, out_p, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      do_op(24'h123456, 24'h000003, lat);
      checks++;
      if (lat !== W || out_p !== 48'h000000369D02) begin
         errors++;
         $display("FAIL midrun_after: got lat=%0d p=%h expected lat=%0d p=%h",
                  lat, out_p, W, 48'h000000369D02);
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp_p;
      int             prev_cyc;
      int             acc_cyc;
      int             n;
      @(negedge clk);
      a         = W'($urandom_range(1, (1 << W) - 1));
      b         = W'($urandom_range(1, (1 << W) - 1));
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      prev_cyc  = 0;
      for (int i = 0; i < 100; i++) begin
         n = 0;
         while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL b2b_accept_timeout: op %0d got no in_ready expected ready", i);
            break;
         end
         exp_p   = (2 * W)'(a) * (2 * W)'(b);
         acc_cyc = cyc;
         if (i > 0) begin
            checks++;
            if (acc_cyc - prev_cyc !== W + 2) begin
               errors++;
               $display("FAIL b2b_spacing: op %0d got %0d cycles expected %0d",
                        i, acc_cyc - prev_cyc, W + 2);
            end
         end
         prev_cyc = acc_cyc;
         @(posedge clk);
         @(negedge clk);
         a    = W'($urandom_range(1, (1 << W) - 1));
         b    = W'($urandom_range(1, (1 << W) - 1));
         in_a = a;
         in_b = b;
         n = 0;
         while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (out_valid !== 1'b1 || out_p !== exp_p) begin
            errors++;
            $display("FAIL b2b_product: op %0d got vld=%b p=%h expected p=%h",
                     i, out_valid, out_p, exp_p);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      test_reset();
      test_unit();
      test_max();
      test_zero();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
